// File: rtl/ysyx_24110015_lsu_pkg.sv
// Shared definitions for the load/store unit: func3 encodings, FSM states, size helpers.
package ysyx_24110015_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    // Byte-enable pattern for an access of the given size code (func3[1:0]).
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        logic [7:0] m;
        case (size)
            2'b00:   m = 8'h01;
            2'b01:   m = 8'h03;
            2'b10:   m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    // Low-address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_mask(input logic [1:0] size);
        logic [2:0] m;
        case (size)
            2'b00:   m = 3'b000;
            2'b01:   m = 3'b001;
            2'b10:   m = 3'b011;
            default: m = 3'b111;
        endcase
        return m;
    endfunction

    // Whether a func3 encoding names a supported access for this data width.
    function automatic logic f3_legal(input logic [2:0] f3, input logic is64);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
            F3_D, F3_WU:                    ok = is64;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ysyx_24110015_lsu_align.sv
// Lane alignment: store data/mask shift into bus lanes, load data shift and extend.
module ysyx_24110015_lsu_align
    import ysyx_24110015_lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]        i_st_func3,
    input  logic [2:0]        i_st_off,
    input  logic [XLEN-1:0]   i_st_wdata,
    output logic [XLEN-1:0]   o_st_wdata_c,
    output logic [XLEN/8-1:0] o_st_wmask_c,
    input  logic [2:0]        i_ld_func3,
    input  logic [2:0]        i_ld_off,
    input  logic [XLEN-1:0]   i_ld_rdata,
    output logic [XLEN-1:0]   o_ld_data_c
);

    localparam int unsigned BYTES = XLEN / 8;

    logic [BYTES-1:0] w_st_size;
    logic [XLEN-1:0]  w_ld_sh;

    // Store path: bits pushed past the top lane are simply dropped.
    always_comb begin
        w_st_size    = BYTES'(size_mask(i_st_func3[1:0]));
        o_st_wmask_c = w_st_size << i_st_off;
        o_st_wdata_c = i_st_wdata << {i_st_off, 3'b000};
    end

    // Load path: bring the addressed byte lane down to bit 0, then extend.
    always_comb begin
        w_ld_sh     = i_ld_rdata >> {i_ld_off, 3'b000};
        o_ld_data_c = w_ld_sh;
        case (i_ld_func3)
            F3_B:    o_ld_data_c = XLEN'($signed(w_ld_sh[7:0]));
            F3_H:    o_ld_data_c = XLEN'($signed(w_ld_sh[15:0]));
            F3_W:    o_ld_data_c = XLEN'($signed(w_ld_sh[31:0]));
            F3_BU:   o_ld_data_c = XLEN'(w_ld_sh[7:0]);
            F3_HU:   o_ld_data_c = XLEN'(w_ld_sh[15:0]);
            F3_WU:   o_ld_data_c = XLEN'(w_ld_sh[31:0]);
            default: o_ld_data_c = w_ld_sh;
        endcase
    end

endmodule

// File: rtl/ysyx_24110015_lsu.sv
// Load/store unit: execute-stage request -> single bus transaction -> writeback result.
// Optional build macro YSYX_24110015_LSU_MISALIGN_EN faults accesses not aligned to their size.
module ysyx_24110015_lsu
    import ysyx_24110015_lsu_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [XLEN-1:0]   in_wdata,
    input  logic [2:0]        in_func3,
    input  logic              in_ren,
    input  logic              in_wen,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_rdata,
    output logic              out_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_wen,
    output logic [XLEN-1:0]   mem_req_wdata,
    output logic [XLEN/8-1:0] mem_req_wmask,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rsp_rdata,
    input  logic              mem_rsp_err
);

    localparam int unsigned BYTES = XLEN / 8;
    localparam int unsigned OFF_W = $clog2(BYTES);
    localparam logic        IS64  = (XLEN == 64);

    lsu_state_e        r_state;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [XLEN-1:0]   r_out_rdata;
    logic              r_out_err;
    logic              r_req_valid;
    logic [ADDR_W-1:0] r_req_addr;
    logic              r_req_wen;
    logic [XLEN-1:0]   r_req_wdata;
    logic [BYTES-1:0]  r_req_wmask;
    logic [2:0]        r_func3;
    logic [2:0]        r_off;

    logic [2:0]        w_in_off;
    logic [XLEN-1:0]   w_st_wdata;
    logic [BYTES-1:0]  w_st_wmask;
    logic [XLEN-1:0]   w_ld_data;
    logic              w_misalign;
    logic              w_fault;

    assign w_in_off = 3'(in_addr[OFF_W-1:0]);

    ysyx_24110015_lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .i_st_func3   (in_func3),
        .i_st_off     (w_in_off),
        .i_st_wdata   (in_wdata),
        .o_st_wdata_c (w_st_wdata),
        .o_st_wmask_c (w_st_wmask),
        .i_ld_func3   (r_func3),
        .i_ld_off     (r_off),
        .i_ld_rdata   (mem_rsp_rdata),
        .o_ld_data_c  (w_ld_data)
    );

`ifdef YSYX_24110015_LSU_MISALIGN_EN
    // Any set offset bit below the access size means the access straddles its natural boundary.
    assign w_misalign = |(w_in_off & align_mask(in_func3[1:0]));
`else
    assign w_misalign = 1'b0;
`endif

    // Requests that fault before touching the bus: conflicting selects, bad encoding, misalignment.
    assign w_fault = (in_ren && in_wen)
                   || ((in_ren || in_wen) && (!f3_legal(in_func3, IS64) || w_misalign));

    // Transaction FSM with all handshake and result outputs held in registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_rdata <= '0;
            r_out_err   <= 1'b0;
            r_req_valid <= 1'b0;
            r_req_addr  <= '0;
            r_req_wen   <= 1'b0;
            r_req_wdata <= '0;
            r_req_wmask <= '0;
            r_func3     <= 3'b000;
            r_off       <= 3'b000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_in_ready <= 1'b0;
                        r_func3    <= in_func3;
                        r_off      <= w_in_off;
                        if (w_fault || (!in_ren && !in_wen)) begin
                            r_state     <= ST_RESP;
                            r_out_valid <= 1'b1;
                            r_out_err   <= w_fault;
                            r_out_rdata <= '0;
                        end else begin
                            r_state     <= ST_REQ;
                            r_req_valid <= 1'b1;
                            r_req_addr  <= {in_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                            r_req_wen   <= in_wen;
                            r_req_wdata <= in_wen ? w_st_wdata : '0;
                            r_req_wmask <= in_wen ? w_st_wmask : '0;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        r_state     <= ST_WAIT;
                        r_req_valid <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (mem_rsp_valid) begin
                        r_state     <= ST_RESP;
                        r_out_valid <= 1'b1;
                        r_out_err   <= mem_rsp_err;
                        r_out_rdata <= (mem_rsp_err || r_req_wen) ? '0 : w_ld_data;
                    end
                end
                ST_RESP: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_out_err   <= 1'b0;
                        r_out_rdata <= '0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready      = r_in_ready;
    assign out_valid     = r_out_valid;
    assign out_rdata     = r_out_rdata;
    assign out_err       = r_out_err;
    assign mem_req_valid = r_req_valid;
    assign mem_req_addr  = r_req_addr;
    assign mem_req_wen   = r_req_wen;
    assign mem_req_wdata = r_req_wdata;
    assign mem_req_wmask = r_req_wmask;

endmodule

// File: tb/tb_ysyx_24110015_lsu.sv
// Directed bench for the LSU: 32-bit instance for most cases, 64-bit instance for doubleword access.
`timescale 1ns/1ps
module tb_ysyx_24110015_lsu;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    // 32-bit DUT signals
    logic        in_valid, in_ready, in_ren, in_wen;
    logic [31:0] in_addr, in_wdata;
    logic [2:0]  in_func3;
    logic        out_valid, out_ready, out_err;
    logic [31:0] out_rdata;
    logic        mem_req_valid, mem_req_ready, mem_req_wen;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_rsp_valid, mem_rsp_err;
    logic [31:0] mem_rsp_rdata;

    // 64-bit DUT signals
    logic        d_in_valid, d_in_ready, d_in_ren, d_in_wen;
    logic [31:0] d_in_addr;
    logic [63:0] d_in_wdata;
    logic [2:0]  d_in_func3;
    logic        d_out_valid, d_out_ready, d_out_err;
    logic [63:0] d_out_rdata;
    logic        d_mem_req_valid, d_mem_req_ready, d_mem_req_wen;
    logic [31:0] d_mem_req_addr;
    logic [63:0] d_mem_req_wdata;
    logic [7:0]  d_mem_req_wmask;
    logic        d_mem_rsp_valid, d_mem_rsp_err;
    logic [63:0] d_mem_rsp_rdata;

    ysyx_24110015_lsu #(.XLEN(32), .ADDR_W(32)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_wdata(in_wdata),
        .in_func3(in_func3), .in_ren(in_ren), .in_wen(in_wen),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err)
    );

    ysyx_24110015_lsu #(.XLEN(64), .ADDR_W(32)) u_dut64 (
        .clk(clk), .rst(rst),
        .in_valid(d_in_valid), .in_ready(d_in_ready), .in_addr(d_in_addr), .in_wdata(d_in_wdata),
        .in_func3(d_in_func3), .in_ren(d_in_ren), .in_wen(d_in_wen),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .out_rdata(d_out_rdata), .out_err(d_out_err),
        .mem_req_valid(d_mem_req_valid), .mem_req_ready(d_mem_req_ready), .mem_req_addr(d_mem_req_addr),
        .mem_req_wen(d_mem_req_wen), .mem_req_wdata(d_mem_req_wdata), .mem_req_wmask(d_mem_req_wmask),
        .mem_rsp_valid(d_mem_rsp_valid), .mem_rsp_rdata(d_mem_rsp_rdata), .mem_rsp_err(d_mem_rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One 32-bit transaction; the bench plays both the bus and the writeback stage.
    task automatic run_txn(
        input  logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] f3,
        input  logic ren, input logic wen,
        input  logic [31:0] rsp_data, input logic rsp_err,
        input  int req_stall, input int out_stall,
        output logic [31:0] rdata, output logic err,
        output int req_cyc, output int out_cyc,
        output logic [31:0] q_addr, output logic [3:0] q_mask, output logic [31:0] q_wdata
    );
        int  n_req_st;
        int  n_out_st;
        bit  rsp_next;
        bit  done;
        n_req_st = 0; n_out_st = 0; rsp_next = 0; done = 0;
        req_cyc = -1; out_cyc = -1;
        rdata = '0; err = 1'b0; q_addr = '0; q_mask = '0; q_wdata = '0;
        in_valid = 1'b1; in_addr = addr; in_wdata = wdata; in_func3 = f3;
        in_ren = ren; in_wen = wen;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= 30 && !done; k++) begin
            mem_rsp_valid = rsp_next;
            mem_rsp_rdata = rsp_data;
            mem_rsp_err   = rsp_err;
            rsp_next      = 0;
            mem_req_ready = 1'b0;
            out_ready     = 1'b0;
            if (mem_req_valid) begin
                if (req_cyc < 0) begin
                    req_cyc = k; q_addr = mem_req_addr; q_mask = mem_req_wmask; q_wdata = mem_req_wdata;
                end else begin
                    chk("req_stable", {mem_req_addr, mem_req_wdata}, {q_addr, q_wdata});
                end
                if (n_req_st == req_stall) begin
                    mem_req_ready = 1'b1;
                    rsp_next      = 1;
                end else begin
                    n_req_st++;
                end
            end
            if (out_valid) begin
                if (out_cyc < 0) begin
                    out_cyc = k; rdata = out_rdata; err = out_err;
                end else begin
                    chk("out_stable", {31'd0, out_err, out_rdata}, {31'd0, err, rdata});
                end
                if (n_out_st == out_stall) begin
                    out_ready = 1'b1;
                    done      = 1;
                end else begin
                    n_out_st++;
                end
            end
            tick();
        end
        mem_rsp_valid = 1'b0; mem_req_ready = 1'b0; out_ready = 1'b0;
        chk("txn_done", 64'(done), 64'd1);
        chk("in_ready_back", 64'(in_ready), 64'd1);
    endtask

    // One 64-bit load with a zero-wait bus.
    task automatic run64(input logic [31:0] addr, input logic [2:0] f3, input logic [63:0] rsp,
                         output logic [63:0] rdata, output logic err);
        bit rsp_next;
        bit done;
        rsp_next = 0; done = 0; rdata = '0; err = 1'b0;
        d_in_valid = 1'b1; d_in_addr = addr; d_in_func3 = f3; d_in_ren = 1'b1; d_in_wen = 1'b0;
        tick();
        d_in_valid = 1'b0;
        for (int k = 1; k <= 30 && !done; k++) begin
            d_mem_rsp_valid = rsp_next;
            d_mem_rsp_rdata = rsp;
            rsp_next        = 0;
            d_mem_req_ready = d_mem_req_valid;
            if (d_mem_req_valid) rsp_next = 1;
            d_out_ready = d_out_valid;
            if (d_out_valid) begin
                rdata = d_out_rdata; err = d_out_err; done = 1;
            end
            tick();
        end
        d_mem_rsp_valid = 1'b0; d_mem_req_ready = 1'b0; d_out_ready = 1'b0;
        chk("txn64_done", 64'(done), 64'd1);
    endtask

    logic [31:0] rd, qa, qw;
    logic [3:0]  qm;
    logic        er;
    int          rc, oc;
    logic [63:0] rd64;
    logic        er64;

    initial begin
        n_tests = 0; n_fail = 0;
        rst = 1'b1;
        in_valid = 0; in_addr = 0; in_wdata = 0; in_func3 = 0; in_ren = 0; in_wen = 0;
        out_ready = 0; mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = 0; mem_rsp_err = 0;
        d_in_valid = 0; d_in_addr = 0; d_in_wdata = 0; d_in_func3 = 0; d_in_ren = 0; d_in_wen = 0;
        d_out_ready = 0; d_mem_req_ready = 0; d_mem_rsp_valid = 0; d_mem_rsp_rdata = 0; d_mem_rsp_err = 0;
        tick(); tick();
        rst = 1'b0;

        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_out_rdata", 64'(out_rdata), 64'd0);
        chk("rst_out_err", 64'(out_err), 64'd0);

        // sb into the top byte lane; store result reads back as zero
        run_txn(32'h8000_0003, 32'h0000_00AB, 3'b000, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 0, 0,
                rd, er, rc, oc, qa, qm, qw);
        chk("sb_addr", 64'(qa), 64'h8000_0000);
        chk("sb_mask", 64'(qm), 64'h8);
        chk("sb_wdata", 64'(qw), 64'hAB00_0000);
        chk("sb_rdata", 64'(rd), 64'd0);
        chk("sb_err", 64'(er), 64'd0);
        chk("sb_req_lat", 64'(rc), 64'd1);
        chk("sb_out_lat", 64'(oc), 64'd3);

        // sh at offset 2
        run_txn(32'h8000_0002, 32'h0000_1234, 3'b001, 1'b0, 1'b1, 32'h0, 1'b0, 0, 0,
                rd, er, rc, oc, qa, qm, qw);
        chk("sh_mask", 64'(qm), 64'hC);
        chk("sh_wdata", 64'(qw), 64'h1234_0000);

        // lh / lhu from the upper half
        run_txn(32'h8000_0002, 32'h0, 3'b001, 1'b1, 1'b0, 32'h8001_1234, 1'b0, 0, 0,
                rd, er, rc, oc, qa, qm, qw);
        chk("lh_rdata", 64'(rd), 64'hFFFF_8001);
        chk("lh_addr", 64'(qa), 64'h8000_0000);
        run_txn(32'h8000_0002, 32'h0, 3'b101, 1'b1, 1'b0, 32'h8001_1234, 1'b0, 0, 0,
                rd, er, rc, oc, qa, qm, qw);
        chk("lhu_rdata", 64'(rd), 64'h0000_8001);

        // lb / lbu from byte 1
        run_txn(32'h8000_0001, 32'h0, 3'b000, 1'b1, 1'b0, 32'h0000_80FF, 1'b0, 0, 0,
                rd, er, rc, oc, qa, qm, qw);
        chk("lb_rdata", 64'(rd), 64'hFFFF_FF80);
        run_txn(32'h8000_0001, 32'h0, 3'b100, 1'b1, 1'b0, 32'h0000_80FF, 1'b0, 0, 0,
                rd, er, rc, oc, qa, qm, qw);
        chk("lbu_rdata", 64'(rd), 64'h0000_0080);

        // lw with bus backpressure and writeback stall
        run_txn(32'h8000_0004, 32'h0, 3'b010, 1'b1, 1'b0, 32'h1234_5678, 1'b0, 3, 2,
                rd, er, rc, oc, qa, qm, qw);
        chk("lw_stall_rdata", 64'(rd), 64'h1234_5678);
        chk("lw_stall_addr", 64'(qa), 64'h8000_0004);
        chk("lw_stall_req_lat", 64'(rc), 64'd1);
        chk("lw_stall_out_lat", 64'(oc), 64'd6);

        // bus error drops data
        run_txn(32'h8000_0008, 32'h0, 3'b010, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 0, 0,
                rd, er, rc, oc, qa, qm, qw);
        chk("buserr_err", 64'(er), 64'd1);
        chk("buserr_rdata", 64'(rd), 64'd0);

        // both selects set: fault without bus access
        run_txn(32'h8000_0000, 32'h0, 3'b010, 1'b1, 1'b1, 32'h5555_5555, 1'b0, 0, 0,
                rd, er, rc, oc, qa, qm, qw);
        chk("both_err", 64'(er), 64'd1);
        chk("both_nobus", 64'(rc), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("both_out_lat", 64'(oc), 64'd1);

        // illegal func3 and doubleword on a 32-bit datapath
        run_txn(32'h8000_0000, 32'h0, 3'b111, 1'b1, 1'b0, 32'h5555_5555, 1'b0, 0, 0,
                rd, er, rc, oc, qa, qm, qw);
        chk("f3_111_err", 64'(er), 64'd1);
        chk("f3_111_nobus", 64'(rc), 64'hFFFF_FFFF_FFFF_FFFF);
        run_txn(32'h8000_0000, 32'h0, 3'b011, 1'b1, 1'b0, 32'h5555_5555, 1'b0, 0, 0,
                rd, er, rc, oc, qa, qm, qw);
        chk("ld32_err", 64'(er), 64'd1);
        chk("ld32_rdata", 64'(rd), 64'd0);

        // no-op request
        run_txn(32'h8000_0000, 32'h0, 3'b010, 1'b0, 1'b0, 32'h5555_5555, 1'b0, 0, 0,
                rd, er, rc, oc, qa, qm, qw);
        chk("nop_err", 64'(er), 64'd0);
        chk("nop_rdata", 64'(rd), 64'd0);
        chk("nop_nobus", 64'(rc), 64'hFFFF_FFFF_FFFF_FFFF);

        // misaligned lw
        run_txn(32'h8000_0001, 32'h0, 3'b010, 1'b1, 1'b0, 32'hAABB_CCDD, 1'b0, 0, 0,
                rd, er, rc, oc, qa, qm, qw);
`ifdef YSYX_24110015_LSU_MISALIGN_EN
        chk("mis_err", 64'(er), 64'd1);
        chk("mis_rdata", 64'(rd), 64'd0);
        chk("mis_nobus", 64'(rc), 64'hFFFF_FFFF_FFFF_FFFF);
`else
        chk("mis_err", 64'(er), 64'd0);
        chk("mis_rdata", 64'(rd), 64'h00AA_BBCC);
        chk("mis_bus", 64'(rc), 64'd1);
        chk("mis_addr", 64'(qa), 64'h8000_0000);
`endif

        // reset while waiting for the response; the late response must be ignored
        in_valid = 1'b1; in_addr = 32'h8000_0010; in_func3 = 3'b010; in_ren = 1'b1; in_wen = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("rstw_req_valid", 64'(mem_req_valid), 64'd1);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hCAFE_F00D; mem_rsp_err = 1'b0;
        chk("rstw_in_ready", 64'(in_ready), 64'd1);
        tick();
        mem_rsp_valid = 1'b0;
        chk("rstw_out_valid", 64'(out_valid), 64'd0);
        chk("rstw_out_rdata", 64'(out_rdata), 64'd0);
        chk("rstw_req_idle", 64'(mem_req_valid), 64'd0);
        tick();
        chk("rstw_out_valid2", 64'(out_valid), 64'd0);
        chk("rstw_in_ready2", 64'(in_ready), 64'd1);

        // recovery after reset
        run_txn(32'h8000_0000, 32'h0, 3'b010, 1'b1, 1'b0, 32'h0BAD_F00D, 1'b0, 0, 0,
                rd, er, rc, oc, qa, qm, qw);
        chk("post_rst_rdata", 64'(rd), 64'h0BAD_F00D);

        // 64-bit datapath
        run64(32'h8000_0008, 3'b011, 64'h0123_4567_89AB_CDEF, rd64, er64);
        chk("ld64_rdata", rd64, 64'h0123_4567_89AB_CDEF);
        chk("ld64_err", 64'(er64), 64'd0);
        run64(32'h8000_0004, 3'b010, 64'hFEDC_BA98_0000_0000, rd64, er64);
        chk("lw64_rdata", rd64, 64'hFFFF_FFFF_FEDC_BA98);
        run64(32'h8000_0004, 3'b110, 64'hFEDC_BA98_0000_0000, rd64, er64);
        chk("lwu64_rdata", rd64, 64'h0000_0000_FEDC_BA98);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
